// File: rtl/rtc_calendar_core.sv
// BCD real-time clock/calendar register bank: holds date and time, advances once per
// tick_1hz with full second-to-year rollover, and loads edited fields while edit_active.
module rtc_calendar_core #(
  parameter logic [15:0] RST_YEAR  = 16'h2024,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        edit_active,
  input  logic [15:0] year_bcd_in,
  input  logic [7:0]  month_bcd_in,
  input  logic [7:0]  day_bcd_in,
  input  logic [7:0]  hour_bcd_in,
  input  logic [7:0]  minute_bcd_in,
  input  logic [7:0]  second_bcd_in,
  output logic [15:0] year_bcd_out,
  output logic [7:0]  month_bcd_out,
  output logic [7:0]  day_bcd_out,
  output logic [7:0]  hour_bcd_out,
  output logic [7:0]  minute_bcd_out,
  output logic [7:0]  second_bcd_out,
  output logic        sec_strobe,
  output logic        day_strobe
);

  localparam int unsigned YW = 16;
  localparam int unsigned FW = 8;

  logic [YW-1:0] year_q, year_d;
  logic [FW-1:0] month_q, month_d;
  logic [FW-1:0] day_q, day_d;
  logic [FW-1:0] hour_q, hour_d;
  logic [FW-1:0] minute_q, minute_d;
  logic [FW-1:0] second_q, second_d;
  logic          sec_stb_q, sec_stb_d;
  logic          day_stb_q, day_stb_d;

  logic [FW-1:0] dim_in;
  logic [FW-1:0] dim_cur;

  // Divisible-by-4 test on a BCD digit pair without converting to binary.
  function automatic logic mod4_bcd(input logic [7:0] p);
    logic [3:0] t;
    logic [3:0] u;
    t = p[7:4];
    u = p[3:0];
    if (!t[0]) return (u == 4'h0) || (u == 4'h4) || (u == 4'h8);
    else       return (u == 4'h2) || (u == 4'h6);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    return mod4_bcd(y[7:0]) && ((y[7:0] != 8'h00) || mod4_bcd(y[15:8]));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] inc2(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {4'(v[7:4] + 4'h1), 4'h0};
    else                return {v[7:4], 4'(v[3:0] + 4'h1)};
  endfunction

  // Four-digit BCD increment; 9999 wraps to 0000 through the digit carries.
  function automatic logic [15:0] inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'h9) begin
          r[i*4 +: 4] = 4'h0;
        end else begin
          r[i*4 +: 4] = 4'(v[i*4 +: 4] + 4'h1);
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign dim_in  = days_in_month(month_bcd_in, year_bcd_in);
  assign dim_cur = days_in_month(month_q, year_q);

  // Next-state: edit load with day clamp, or one-tick ripple through all fields.
  always_comb begin
    year_d    = year_q;
    month_d   = month_q;
    day_d     = day_q;
    hour_d    = hour_q;
    minute_d  = minute_q;
    second_d  = second_q;
    sec_stb_d = 1'b0;
    day_stb_d = 1'b0;
    if (edit_active) begin
      year_d   = year_bcd_in;
      month_d  = month_bcd_in;
      day_d    = (day_bcd_in > dim_in) ? dim_in : day_bcd_in;
      hour_d   = hour_bcd_in;
      minute_d = minute_bcd_in;
      second_d = second_bcd_in;
    end else if (tick_1hz) begin
      sec_stb_d = 1'b1;
      if (second_q != 8'h59) begin
        second_d = inc2(second_q);
      end else begin
        second_d = 8'h00;
        if (minute_q != 8'h59) begin
          minute_d = inc2(minute_q);
        end else begin
          minute_d = 8'h00;
          if (hour_q != 8'h23) begin
            hour_d = inc2(hour_q);
          end else begin
            hour_d    = 8'h00;
            day_stb_d = 1'b1;
            if (day_q != dim_cur) begin
              day_d = inc2(day_q);
            end else begin
              day_d = 8'h01;
              if (month_q != 8'h12) begin
                month_d = inc2(month_q);
              end else begin
                month_d = 8'h01;
                year_d  = inc4(year_q);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_q    <= RST_YEAR;
      month_q   <= RST_MONTH;
      day_q     <= RST_DAY;
      hour_q    <= 8'h00;
      minute_q  <= 8'h00;
      second_q  <= 8'h00;
      sec_stb_q <= 1'b0;
      day_stb_q <= 1'b0;
    end else begin
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      hour_q    <= hour_d;
      minute_q  <= minute_d;
      second_q  <= second_d;
      sec_stb_q <= sec_stb_d;
      day_stb_q <= day_stb_d;
    end
  end

  assign year_bcd_out   = year_q;
  assign month_bcd_out  = month_q;
  assign day_bcd_out    = day_q;
  assign hour_bcd_out   = hour_q;
  assign minute_bcd_out = minute_q;
  assign second_bcd_out = second_q;
  assign sec_strobe     = sec_stb_q;
  assign day_strobe     = day_stb_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core: edit loads, day clamp, leap-year and
// year rollover, strobes, tick-during-edit and asynchronous reset.
module tb_rtc_calendar_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic        edit_active;
  logic [15:0] year_bcd_in;
  logic [7:0]  month_bcd_in, day_bcd_in, hour_bcd_in, minute_bcd_in, second_bcd_in;
  logic [15:0] year_bcd_out;
  logic [7:0]  month_bcd_out, day_bcd_out, hour_bcd_out, minute_bcd_out, second_bcd_out;
  logic        sec_strobe, day_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  rtc_calendar_core dut (
    .clk            (clk),
    .rst            (rst),
    .tick_1hz       (tick_1hz),
    .edit_active    (edit_active),
    .year_bcd_in    (year_bcd_in),
    .month_bcd_in   (month_bcd_in),
    .day_bcd_in     (day_bcd_in),
    .hour_bcd_in    (hour_bcd_in),
    .minute_bcd_in  (minute_bcd_in),
    .second_bcd_in  (second_bcd_in),
    .year_bcd_out   (year_bcd_out),
    .month_bcd_out  (month_bcd_out),
    .day_bcd_out    (day_bcd_out),
    .hour_bcd_out   (hour_bcd_out),
    .minute_bcd_out (minute_bcd_out),
    .second_bcd_out (second_bcd_out),
    .sec_strobe     (sec_strobe),
    .day_strobe     (day_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] now();
    return {8'h00, year_bcd_out, month_bcd_out, day_bcd_out,
            hour_bcd_out, minute_bcd_out, second_bcd_out};
  endfunction

  function automatic logic [63:0] stb();
    return {62'd0, sec_strobe, day_strobe};
  endfunction

  // Advance one edge; inputs and samples sit 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [55:0] v);
    {year_bcd_in, month_bcd_in, day_bcd_in, hour_bcd_in, minute_bcd_in, second_bcd_in} = v;
  endtask

  task automatic load(input logic [55:0] v);
    edit_active = 1'b1;
    set_in(v);
    step();
    edit_active = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  // Load a timestamp, release edit with a tick on that first RUN cycle, check result.
  task automatic load_tick(input string tag, input logic [55:0] v, input logic [55:0] exp,
                           input logic [1:0] exp_stb);
    load(v);
    tick();
    check({tag, "_time"}, now(), {8'h00, exp});
    check({tag, "_stb"}, stb(), {62'd0, exp_stb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; edit_active = 1'b0;
    set_in(56'h0);
    #12;
    check("rst_time", now(), 64'h00_2024_01_01_00_00_00);
    check("rst_stb", stb(), 64'd0);
    step();
    rst = 1'b0;
    step(); step();
    check("post_rst_hold", now(), 64'h00_2024_01_01_00_00_00);

    // Year/day/second carry together, both strobes for one cycle.
    load_tick("newyear", 56'h2023_12_31_23_59_59, 56'h2024_01_01_00_00_00, 2'b11);
    step();
    check("newyear_stb_clear", stb(), 64'd0);
    check("newyear_hold", now(), 64'h00_2024_01_01_00_00_00);

    load_tick("leap2024", 56'h2024_02_28_23_59_59, 56'h2024_02_29_00_00_00, 2'b11);
    load_tick("feb29end", 56'h2024_02_29_23_59_59, 56'h2024_03_01_00_00_00, 2'b11);
    load_tick("noleap2100", 56'h2100_02_28_23_59_59, 56'h2100_03_01_00_00_00, 2'b11);
    load_tick("leap2000", 56'h2000_02_28_23_59_59, 56'h2000_02_29_00_00_00, 2'b11);
    load_tick("noleap2023", 56'h2023_02_28_23_59_59, 56'h2023_03_01_00_00_00, 2'b11);
    load_tick("leap0000", 56'h0000_02_28_23_59_59, 56'h0000_02_29_00_00_00, 2'b11);
    load_tick("apr30", 56'h2024_04_30_23_59_59, 56'h2024_05_01_00_00_00, 2'b11);
    load_tick("sep30", 56'h2024_09_30_23_59_59, 56'h2024_10_01_00_00_00, 2'b11);
    load_tick("y9999", 56'h9999_12_31_23_59_59, 56'h0000_01_01_00_00_00, 2'b11);
    load_tick("y1999", 56'h1999_12_31_23_59_59, 56'h2000_01_01_00_00_00, 2'b11);
    load_tick("sec_x9", 56'h2024_06_15_12_34_09, 56'h2024_06_15_12_34_10, 2'b10);
    load_tick("min_carry", 56'h2024_06_15_12_59_59, 56'h2024_06_15_13_00_00, 2'b10);
    load_tick("hr_x9", 56'h2024_06_15_09_59_59, 56'h2024_06_15_10_00_00, 2'b10);

    // No tick: fields hold, strobes drop.
    step(); step(); step();
    check("run_hold", now(), 64'h00_2024_06_15_10_00_00);
    check("run_hold_stb", stb(), 64'd0);
    tick(); tick();
    check("two_ticks", now(), 64'h00_2024_06_15_10_00_02);

    // Day clamp on load.
    load(56'h2024_04_31_08_00_00);
    check("clamp_apr", now(), 64'h00_2024_04_30_08_00_00);
    load(56'h2023_02_30_08_00_00);
    check("clamp_feb23", now(), 64'h00_2023_02_28_08_00_00);
    load(56'h2024_02_31_08_00_00);
    check("clamp_feb24", now(), 64'h00_2024_02_29_08_00_00);

    // Ticks every cycle while editing: fields track inputs, no increment.
    edit_active = 1'b1;
    tick_1hz    = 1'b1;
    set_in(56'h2030_07_04_11_22_33); step();
    check("edit_tick_a", now(), 64'h00_2030_07_04_11_22_33);
    check("edit_tick_a_stb", stb(), 64'd0);
    set_in(56'h2031_08_05_12_23_59); step();
    check("edit_tick_b", now(), 64'h00_2031_08_05_12_23_59);
    step();
    check("edit_tick_c", now(), 64'h00_2031_08_05_12_23_59);
    check("edit_tick_c_stb", stb(), 64'd0);
    tick_1hz    = 1'b0;
    edit_active = 1'b0;
    step();
    check("edit_release_hold", now(), 64'h00_2031_08_05_12_23_59);
    tick();
    check("after_edit_tick", now(), 64'h00_2031_08_05_12_24_00);

    // Async reset mid-run takes effect before the next edge.
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_time", now(), 64'h00_2024_01_01_00_00_00);
    check("async_rst_stb", stb(), 64'd0);
    step();
    rst = 1'b0;
    tick();
    check("post_async_tick", now(), 64'h00_2024_01_01_00_00_01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
